// File: rtl/cnn_mem_defs.sv
`default_nettype none
// ==========================================================================
// cnn_mem_defs: shared constants and FSM encoding for the CNN test memory. Rev 1.0
// ==========================================================================
package cnn_mem_defs;

  localparam int          DW      = 32;
  localparam int          AW      = 17;
  localparam int unsigned DEPTH   = 129054;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // True when the block [base, base+len) runs past the last valid word.
  function automatic logic range_exceeds(input logic [AW-1:0] base,
                                         input logic [AW-1:0] len);
    logic [AW:0] sum;
    sum = {1'b0, base} + {1'b0, len};
    return (sum > DEPTH_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_skid_fifo.sv
`default_nettype none
// ==========================================================================
// tmr_skid_fifo: 2-entry fall-through FIFO; an incoming word is visible on head
// in the cycle it is pushed when the FIFO is empty. Rev 1.0
// ==========================================================================
module tmr_skid_fifo
  import cnn_mem_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;
  logic          w_empty;
  logic          w_store;
  logic          w_deq;

  assign w_empty = (cnt_q == 2'd0);
  assign valid   = !w_empty || push;
  assign head    = !w_empty ? mem_q[rd_q] : (push ? push_data : '0);
  assign count   = cnt_q;

  // A word popped in the same cycle it arrives into an empty FIFO is never stored.
  assign w_store = push && !(w_empty && pop);
  assign w_deq   = pop && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      if (w_store) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (w_deq) begin
        rd_q <= ~rd_q;
      end
      case ({w_store, w_deq})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_mem_reader.sv
`default_nettype none
// ==========================================================================
// test_mem_reader: streams a (base, length) block of the CNN test memory onto a
// valid/ready stream and pulses done (with err on an out-of-range block). Rev 1.0
// ==========================================================================
module test_mem_reader
  import cnn_mem_defs::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state_q;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] remaining_q;
  logic          inflight_q;
  logic          err_q;

  logic [1:0]    w_count;
  logic          w_pop;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic          w_range_err;

  tmr_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (w_pop),
    .head      (dout),
    .valid     (dout_valid),
    .count     (w_count)
  );

  assign w_pop = dout_valid && dout_ready;

  // Occupancy left after this cycle's pop; counting the pop as a credit lets
  // reads issue every cycle while the consumer keeps up.
  assign w_occ       = {1'b0, w_count} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_issue     = (state_q == ST_READ) && (remaining_q != '0) && (w_occ < 3'd2);
  assign w_range_err = range_exceeds(addr_q, remaining_q);

  assign mem_en   = w_issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q == ST_CHECK) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_FIN);
  assign err      = (state_q == ST_FIN) && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      inflight_q <= w_issue;
      if (state_q == ST_IDLE && start) begin
        addr_q      <= base_addr;
        remaining_q <= length;
        err_q       <= 1'b0;
      end
      if (state_q == ST_CHECK) begin
        err_q <= w_range_err;
      end
      if (w_issue) begin
        addr_q      <= addr_q + AW'(1);
        remaining_q <= remaining_q - AW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_range_err || remaining_q == '0) state_nxt = ST_FIN;
        else                                  state_nxt = ST_READ;
      end
      ST_READ:  if (w_issue && remaining_q == AW'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_occ == 3'd0) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_test_mem_reader.sv
`default_nettype none
// ==========================================================================
// tb_test_mem_reader: scoreboard bench for test_mem_reader with a 1-cycle memory model. Rev 1.0
// ==========================================================================
module tb_test_mem_reader;
  import cnn_mem_defs::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int ready_mode = 0;
  int stall_lo   = 0;
  int stall_hi   = 0;

  logic [DW-1:0] exp_q[$];
  int   issue_cnt, xfer_cnt, done_cnt, err_cnt;
  int   first_valid_cyc, last_xfer_cyc, done_cyc;
  int   outstanding = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  test_mem_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= mem_word(mem_addr);

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) dout_ready = 1'b1;
      else dout_ready = ((cyc % 2) == 0) && !(cyc >= stall_lo && cyc < stall_hi);
    end
  end

  // Stream monitor: scoreboard pops, hold-under-stall, credit and range invariants.
  always @(negedge clk) begin
    logic xfer;
    logic [DW-1:0] e;
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      xfer = dout_valid && dout_ready;
      if (prev_stall) begin
        checks++;
        if (!dout_valid || dout !== prev_dout) begin
          errors++;
          $display("FAIL hold: dout=%h valid=%b, required dout=%h valid=1", dout, dout_valid, prev_dout);
        end
      end
      if (dout_valid) begin
        checks++;
        if (!busy) begin
          errors++;
          $display("FAIL valid_outside_cmd: dout_valid=1 busy=%b, required busy=1", busy);
        end
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (mem_en) begin
        issue_cnt++;
        checks++;
        if (mem_addr >= DEPTH || (outstanding - int'(xfer)) >= 2) begin
          errors++;
          $display("FAIL issue: addr=%0d held=%0d, required addr<%0d held<2", mem_addr, outstanding - int'(xfer), DEPTH);
        end
      end
      if (xfer) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, required no transfer", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            errors++;
            $display("FAIL data: got %h, required %h", dout, e);
          end
        end
      end
      outstanding += int'(mem_en) - int'(xfer);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (err) err_cnt++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  task automatic clear_stats();
    issue_cnt = 0; xfer_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_valid_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
  endtask

  task automatic send_cmd(input int base, input int len, input int npush, output int s);
    @(posedge clk);
    #1;
    clear_stats();
    base_addr = AW'(base);
    length    = AW'(len);
    start     = 1'b1;
    for (int i = 0; i < npush; i++) exp_q.push_back(mem_word(AW'(base + i)));
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_en, dout_valid, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: {en,valid,busy,done,err}=%b, required 00000", {mem_en, dout_valid, busy, done, err});
    end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", mem_addr); end
    checks++;
    if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h, required 0", dout); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int s; bit got;
    ready_mode = 0;
    send_cmd(100, 8, 8, s);
    wait_done(40, got);
    checks++;
    if (!got) begin errors++; $display("FAIL basic_timeout: done=0, required done within 40 cycles"); end
    checks++;
    if (first_valid_cyc != s + 3) begin errors++; $display("FAIL basic_latency: first valid at +%0d, required +3", first_valid_cyc - s); end
    checks++;
    if (last_xfer_cyc - first_valid_cyc != 7 || xfer_cnt != 8) begin
      errors++; $display("FAIL basic_b2b: span=%0d words=%0d, required span=7 words=8", last_xfer_cyc - first_valid_cyc, xfer_cnt);
    end
    checks++;
    if (done_cyc != last_xfer_cyc + 1) begin errors++; $display("FAIL basic_done: done at %0d, required %0d", done_cyc, last_xfer_cyc + 1); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err_cnt != 0 || done_cnt != 1 || issue_cnt != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL basic_totals: err=%0d done=%0d issues=%0d left=%0d, required 0 1 8 0", err_cnt, done_cnt, issue_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int s; bit got;
    ready_mode = 1;
    stall_lo = cyc + 8;
    stall_hi = cyc + 13;
    send_cmd(0, 16, 16, s);
    wait_done(150, got);
    ready_mode = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL bp_timeout: done=0, required done within 150 cycles"); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (xfer_cnt != 16 || exp_q.size() != 0 || issue_cnt != 16) begin
      errors++; $display("FAIL bp_totals: words=%0d left=%0d issues=%0d, required 16 0 16", xfer_cnt, exp_q.size(), issue_cnt);
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL bp_done: done=%0d err=%0d, required 1 0", done_cnt, err_cnt); end
  endtask

  task automatic test_boundaries();
    int s; bit got;
    send_cmd(300, 0, 0, s);
    wait_done(10, got);
    checks++;
    if (!got || done_cyc != s + 2 || issue_cnt != 0 || err_cnt != 0) begin
      errors++; $display("FAIL zero_len: done at +%0d issues=%0d err=%0d, required +2 0 0", done_cyc - s, issue_cnt, err_cnt);
    end
    send_cmd(129050, 5, 0, s);
    wait_done(10, got);
    checks++;
    if (!got || done_cyc != s + 2 || issue_cnt != 0 || err_cnt != 1) begin
      errors++; $display("FAIL range_err: done at +%0d issues=%0d err=%0d, required +2 0 1", done_cyc - s, issue_cnt, err_cnt);
    end
    send_cmd(129053, 1, 1, s);
    wait_done(20, got);
    checks++;
    if (!got || xfer_cnt != 1 || issue_cnt != 1 || err_cnt != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL last_word: words=%0d issues=%0d err=%0d left=%0d, required 1 1 0 0", xfer_cnt, issue_cnt, err_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s; bit got; bit seen;
    send_cmd(0, int'(DEPTH), 8, s);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (xfer_cnt >= 3) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || err_cnt != 0 || done_cnt != 0) begin
      errors++; $display("FAIL full_len_legal: words=%0d err=%0d done=%0d, required >=3 0 0", xfer_cnt, err_cnt, done_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_en, dout_valid, busy, done, err} !== 5'b0 || mem_addr !== '0 || dout !== '0) begin
      errors++; $display("FAIL reset_mid: ctrl=%b addr=%0d dout=%h, required all 0", {mem_en, dout_valid, busy, done, err}, mem_addr, dout);
    end
    @(negedge clk);
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL stale_drop: dout_valid=%b, required 0", dout_valid); end
    send_cmd(10, 2, 2, s);
    wait_done(20, got);
    checks++;
    if (!got || xfer_cnt != 2 || exp_q.size() != 0 || err_cnt != 0) begin
      errors++; $display("FAIL after_reset: words=%0d left=%0d err=%0d, required 2 0 0", xfer_cnt, exp_q.size(), err_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int s; bit got;
    send_cmd(200, 4, 4, s);
    @(posedge clk);
    #1;
    base_addr = AW'(500);
    length    = AW'(9);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(30, got);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (!got || done_cnt != 1 || xfer_cnt != 4 || issue_cnt != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL start_busy: done=%0d words=%0d issues=%0d left=%0d, required 1 4 4 0", done_cnt, xfer_cnt, issue_cnt, exp_q.size());
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
